qdi_1of2_bridge: RTL and testbench

Clocked bridge between binary handshake logic and 1-of-2 (dual-rail) four-phase QDI channels.
- Transmit half (encoder, `bin2qdi_1of2_tx`) turns a binary word plus a go request into a dual-rail token, then returns it to zero under the receiver's enable.
- Receive half (decoder, `qdi2bin_1of2_rx`) completion-detects an incoming dual-rail token, presents it as binary data with a valid flag, and drives the channel enable.
- Used by testbenches and the sync/async boundary in front of QDI datapaths such as the full adder.

---
 rtl/qdi_pkg.sv | 33 +++
 rtl/bin2qdi_1of2_tx.sv | 61 ++++++
 rtl/qdi2bin_1of2_rx.sv | 80 ++++++++
 rtl/qdi_1of2_bridge.sv | 42 ++++
 tb/tb_qdi_1of2_bridge.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/qdi_pkg.sv
// Shared dual-rail (1-of-2) encoding helpers and TX state type for the QDI bridge.
// Helpers work on a single bit pair; callers reduce across the word.
package qdi_pkg;

    localparam bit FALSE_RAIL = 1'b0;
    localparam bit TRUE_RAIL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        NULL
    } tx_state_e;

    function automatic logic [1:0] dr_encode(input logic bin);
        logic [1:0] pair;
        pair[TRUE_RAIL]  = bin;
        pair[FALSE_RAIL] = ~bin;
        return pair;
    endfunction

    function automatic logic dr_complete(input logic [1:0] pair);
        return pair[TRUE_RAIL] ^ pair[FALSE_RAIL];
    endfunction

    function automatic logic dr_neutral(input logic [1:0] pair);
        return ~(pair[TRUE_RAIL] | pair[FALSE_RAIL]);
    endfunction

    function automatic logic dr_illegal(input logic [1:0] pair);
        return pair[TRUE_RAIL] & pair[FALSE_RAIL];
    endfunction

endpackage

// File: rtl/bin2qdi_1of2_tx.sv
// Binary-to-dual-rail encoder: launches one four-phase token per go episode.
module bin2qdi_1of2_tx
    import qdi_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic               go_i,
    input  logic               en_i,
    output logic [2*WIDTH-1:0] rails_o
);

    tx_state_e          state_q, state_d;
    logic [2*WIDTH-1:0] rails_q, rails_d;

    always_comb begin
        state_d = state_q;
        rails_d = rails_q;
        unique case (state_q)
            IDLE: begin
                if (go_i && en_i) begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        rails_d[2*i +: 2] = dr_encode(data_i[i]);
                    end
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!en_i) begin
                    rails_d = '0;
                    state_d = NULL;
                end
            end
            // Wait for go to drop so a held request never resends.
            NULL: begin
                if (!go_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                rails_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rails_q <= '0;
        end else begin
            state_q <= state_d;
            rails_q <= rails_d;
        end
    end

    assign rails_o = rails_q;

endmodule

// File: rtl/qdi2bin_1of2_rx.sv
// Dual-rail-to-binary decoder: completion detection, enable generation, sticky 11 error.
module qdi2bin_1of2_rx
    import qdi_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [2*WIDTH-1:0] rails_i,
    output logic               en_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               valid_o,
    output logic               error_o
);

    logic [WIDTH-1:0] pair_ok, pair_nul, pair_bad, true_bits;
    logic [1:0]       pair;
    logic             complete, neutral, illegal;

    always_comb begin
        pair      = '0;
        pair_ok   = '0;
        pair_nul  = '0;
        pair_bad  = '0;
        true_bits = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pair         = rails_i[2*i +: 2];
            pair_ok[i]   = dr_complete(pair);
            pair_nul[i]  = dr_neutral(pair);
            pair_bad[i]  = dr_illegal(pair);
            true_bits[i] = pair[TRUE_RAIL];
        end
        complete = &pair_ok;
        neutral  = &pair_nul;
        illegal  = |pair_bad;
    end

    logic             en_q, en_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] data_q, data_d;

    // An 11 pair freezes the handshake; only reset clears the error.
    always_comb begin
        en_d    = en_q;
        valid_d = valid_q;
        error_d = error_q;
        data_d  = data_q;
        if (illegal) begin
            error_d = 1'b1;
        end else if (en_q && complete) begin
            data_d  = true_bits;
            valid_d = 1'b1;
            en_d    = 1'b0;
        end else if (!en_q && neutral) begin
            valid_d = 1'b0;
            en_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q    <= 1'b1;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            data_q  <= '0;
        end else begin
            en_q    <= en_d;
            valid_q <= valid_d;
            error_q <= error_d;
            data_q  <= data_d;
        end
    end

    assign en_o    = en_q;
    assign valid_o = valid_q;
    assign error_o = error_q;
    assign data_o  = data_q;

endmodule

// File: rtl/qdi_1of2_bridge.sv
// Clocked bridge between binary handshakes and 1-of-2 four-phase QDI channels.
// The transmit and receive halves are fully independent.
module qdi_1of2_bridge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [WIDTH-1:0]   tx_data,
    input  logic               tx_go,
    input  logic               tx_en,
    output logic [2*WIDTH-1:0] tx_rails,
    input  logic [2*WIDTH-1:0] rx_rails,
    output logic               rx_en,
    output logic [WIDTH-1:0]   rx_data,
    output logic               rx_valid,
    output logic               rx_error
);

    bin2qdi_1of2_tx #(
        .WIDTH (WIDTH)
    ) u_tx (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .data_i  (tx_data),
        .go_i    (tx_go),
        .en_i    (tx_en),
        .rails_o (tx_rails)
    );

    qdi2bin_1of2_rx #(
        .WIDTH (WIDTH)
    ) u_rx (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .rails_i (rx_rails),
        .en_o    (rx_en),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .error_o (rx_error)
    );

endmodule

// File: tb/tb_qdi_1of2_bridge.sv
// Directed bench: WIDTH=1 TX/RX, WIDTH=2 RX vector table, WIDTH=3 loopback.
module tb_qdi_1of2_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH = 1 instance
    logic       tx_data_1, tx_go_1, tx_en_1;
    logic [1:0] tx_rails_1, rx_rails_1;
    logic       rx_en_1, rx_data_1, rx_valid_1, rx_error_1;

    // WIDTH = 2 instance (RX table)
    logic [1:0] tx_data_2;
    logic       tx_go_2, tx_en_2;
    logic [3:0] tx_rails_2, rx_rails_2;
    logic       rx_en_2, rx_valid_2, rx_error_2;
    logic [1:0] rx_data_2;

    // WIDTH = 3 instance, looped back
    logic [2:0] tx_data_3, rx_data_3;
    logic       tx_go_3, rx_en_3, rx_valid_3, rx_error_3;
    logic [5:0] tx_rails_3;

    qdi_1of2_bridge #(.WIDTH(1)) u_w1 (
        .CLK(clk), .RESET(rst), .tx_data(tx_data_1), .tx_go(tx_go_1), .tx_en(tx_en_1),
        .tx_rails(tx_rails_1), .rx_rails(rx_rails_1), .rx_en(rx_en_1), .rx_data(rx_data_1),
        .rx_valid(rx_valid_1), .rx_error(rx_error_1)
    );

    qdi_1of2_bridge #(.WIDTH(2)) u_w2 (
        .CLK(clk), .RESET(rst), .tx_data(tx_data_2), .tx_go(tx_go_2), .tx_en(tx_en_2),
        .tx_rails(tx_rails_2), .rx_rails(rx_rails_2), .rx_en(rx_en_2), .rx_data(rx_data_2),
        .rx_valid(rx_valid_2), .rx_error(rx_error_2)
    );

    qdi_1of2_bridge #(.WIDTH(3)) u_w3 (
        .CLK(clk), .RESET(rst), .tx_data(tx_data_3), .tx_go(tx_go_3), .tx_en(rx_en_3),
        .tx_rails(tx_rails_3), .rx_rails(tx_rails_3), .rx_en(rx_en_3), .rx_data(rx_data_3),
        .rx_valid(rx_valid_3), .rx_error(rx_error_3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Count rx_valid rising edges on the loopback channel.
    logic valid3_prev = 1'b0;
    int   rise_cnt    = 0;
    always @(posedge clk) begin
        valid3_prev <= rx_valid_3;
        if (rx_valid_3 && !valid3_prev) rise_cnt <= rise_cnt + 1;
    end

    typedef struct packed {
        logic [3:0] rails;
        logic       valid;
        logic       en;
        logic [1:0] data;
        logic       err;
    } rx_vec_t;

    rx_vec_t vecs [10];

    task automatic send_token(input logic [2:0] val, input string tag);
        int k;
        @(negedge clk);
        tx_data_3 = val;
        tx_go_3   = 1'b1;
        k = 0;
        while (!rx_valid_3 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, k, 2);
        check({tag, "_data"}, {29'd0, rx_data_3}, {29'd0, val});
        k = 0;
        while (!(rx_en_3 && tx_rails_3 == 6'd0) && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_rtz"}, k, 2);
        check({tag, "_err"}, {31'd0, rx_error_3}, 0);
        @(negedge clk);
        tx_go_3 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int base;

        vecs[0] = '{rails: 4'b1001, valid: 1'b1, en: 1'b0, data: 2'b10, err: 1'b0};
        vecs[1] = '{rails: 4'b0000, valid: 1'b0, en: 1'b1, data: 2'b10, err: 1'b0};
        vecs[2] = '{rails: 4'b0001, valid: 1'b0, en: 1'b1, data: 2'b10, err: 1'b0};
        vecs[3] = '{rails: 4'b0110, valid: 1'b1, en: 1'b0, data: 2'b01, err: 1'b0};
        vecs[4] = '{rails: 4'b0100, valid: 1'b1, en: 1'b0, data: 2'b01, err: 1'b0};
        vecs[5] = '{rails: 4'b0000, valid: 1'b0, en: 1'b1, data: 2'b01, err: 1'b0};
        vecs[6] = '{rails: 4'b1010, valid: 1'b1, en: 1'b0, data: 2'b11, err: 1'b0};
        vecs[7] = '{rails: 4'b0000, valid: 1'b0, en: 1'b1, data: 2'b11, err: 1'b0};
        vecs[8] = '{rails: 4'b0011, valid: 1'b0, en: 1'b1, data: 2'b11, err: 1'b1};
        vecs[9] = '{rails: 4'b0000, valid: 1'b0, en: 1'b1, data: 2'b11, err: 1'b1};

        tx_data_1 = 1'b0; tx_go_1 = 1'b0; tx_en_1 = 1'b0; rx_rails_1 = 2'b00;
        tx_data_2 = 2'b00; tx_go_2 = 1'b0; tx_en_2 = 1'b0; rx_rails_2 = 4'b0000;
        tx_data_3 = 3'd0; tx_go_3 = 1'b0;

        // Reset held for 3 cycles, checked during and after
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_rails", {30'd0, tx_rails_1}, 0);
        check("rst_rx_en", {31'd0, rx_en_1}, 1);
        check("rst_rx_state", {29'd0, rx_valid_1, rx_data_1, rx_error_1}, 0);
        check("rst_w3", {25'd0, tx_rails_3, rx_en_3}, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_tx_rails", {30'd0, tx_rails_1}, 0);
        check("post_rst_rx", {28'd0, rx_en_1, rx_valid_1, rx_data_1, rx_error_1}, 4'b1000);

        // TX single token on WIDTH=1
        @(negedge clk);
        tx_data_1 = 1'b1; tx_go_1 = 1'b1; tx_en_1 = 1'b1;
        @(posedge clk); #1;
        check("tx_launch", {30'd0, tx_rails_1}, 2'b10);
        @(negedge clk);
        tx_data_1 = 1'b0;
        @(posedge clk); #1;
        check("tx_hold", {30'd0, tx_rails_1}, 2'b10);
        @(negedge clk);
        tx_en_1 = 1'b0;
        @(posedge clk); #1;
        check("tx_rtz", {30'd0, tx_rails_1}, 2'b00);
        @(negedge clk);
        tx_en_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("tx_no_resend", {30'd0, tx_rails_1}, 2'b00);
        end
        @(negedge clk);
        tx_go_1 = 1'b0;
        @(posedge clk); #1;
        check("tx_null_to_idle", {30'd0, tx_rails_1}, 2'b00);
        @(negedge clk);
        tx_go_1 = 1'b1;
        @(posedge clk); #1;
        check("tx_second_token", {30'd0, tx_rails_1}, 2'b01);
        @(negedge clk);
        tx_en_1 = 1'b0; tx_go_1 = 1'b0;
        @(posedge clk); #1;
        check("tx_second_rtz", {30'd0, tx_rails_1}, 2'b00);

        // RX decode on WIDTH=1
        @(negedge clk);
        rx_rails_1 = 2'b01;
        @(posedge clk); #1;
        check("rx_decode", {29'd0, rx_data_1, rx_valid_1, rx_en_1}, 3'b010);
        @(negedge clk);
        rx_rails_1 = 2'b00;
        @(posedge clk); #1;
        check("rx_neutral", {29'd0, rx_data_1, rx_valid_1, rx_en_1}, 3'b001);
        @(negedge clk);
        rx_rails_1 = 2'b10;
        @(posedge clk); #1;
        check("rx_decode_one", {29'd0, rx_data_1, rx_valid_1, rx_en_1}, 3'b110);

        // RX table on WIDTH=2
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_rails_2 = vecs[i].rails;
            @(posedge clk); #1;
            check($sformatf("rx_vec%0d", i),
                  {27'd0, rx_valid_2, rx_en_2, rx_data_2, rx_error_2},
                  {27'd0, vecs[i].valid, vecs[i].en, vecs[i].data, vecs[i].err});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rx_err_cleared", {31'd0, rx_error_2}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Loopback sweep on WIDTH=3
        base = rise_cnt;
        for (int v = 0; v < 8; v++) begin
            send_token(3'(v), $sformatf("lb%0d", v));
        end
        check("lb_valid_rises", rise_cnt - base, 8);

        // Reset mid-token: tx in DATA, rx holding a valid token
        @(negedge clk);
        tx_data_3 = 3'd5; tx_go_3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_pre_valid", {26'd0, rx_valid_3, tx_rails_3}, {1'b1, 6'b100110});
        #1 rst = 1'b1;
        #1;
        check("mid_async_tx", {26'd0, tx_rails_3}, 0);
        check("mid_async_rx", {30'd0, rx_en_3, rx_valid_3}, 2'b10);
        @(negedge clk);
        rst = 1'b0; tx_go_3 = 1'b0;
        send_token(3'd6, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
